// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the RX sequencer, the TX sequencer and
//   the baud generator.
//   Contents:
//     UART_OVERSAMPLE : baud ticks per bit period
//     UART_DATA_BITS  : data bits per frame
//     rx_state_t      : receive FSM states
//     rx_state_busy() : true while a frame is being received
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // A frame is "in progress" from start detection up to the stop-bit sample.
  function automatic logic rx_state_busy(input rx_state_t s);
    return (s != IDLE) && (s != WAIT_IDLE);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for an asynchronous single-bit input. Both flops
//   preset to 1 so an idle-high line does not look like a falling edge as
//   reset releases. Also used for GPIO inputs.
//   Ports:
//     clk   : sampling clock
//     rst_n : asynchronous active-low reset (flops preset to 1)
//     d_i   : asynchronous input
//     q_o   : synchronized output, 2 clk cycles of latency
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_rx_sequencer
//   UART receive path: 16x oversampled start detection, mid-bit sampling of
//   DATA_BITS data bits (LSB first), optional even/odd parity, stop-bit
//   check, and a one-entry holding register towards the APB register side.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     baud_tick    : one-cycle enable, OVERSAMPLE pulses per bit period
//     rx           : asynchronous serial input, idles high
//     parity_en    : frame carries a parity bit (latched at start detection)
//     parity_odd   : 1 = odd parity, 0 = even (latched at start detection)
//     rx_ready     : consumer takes the held byte this cycle
//     rx_data      : held byte
//     rx_valid     : rx_data / parity_err / frame_err are valid
//     parity_err   : held byte failed its parity check
//     frame_err    : held byte's stop bit was sampled low
//     overrun      : one-cycle pulse, a completed frame was dropped
//     busy         : registered, high while a frame is in progress
//     dbg_state    : current FSM state, for observation only
//
//   Handshake: a held byte transfers on every clock edge where
//   rx_valid && rx_ready. rx_data and the error flags never change while
//   rx_valid && !rx_ready. A frame completing in the same cycle as a
//   transfer replaces the held byte and rx_valid stays high. A frame
//   completing while the held byte is not being taken is dropped and
//   overrun pulses.
// ---------------------------------------------------------------------------
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output rx_state_t            dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  // Start confirmation is half a bit after detection. Every later sample is a
  // full bit after the previous one. OVERSAMPLE is a power of two, so tcnt
  // wraps from OVERSAMPLE-1 to 0 by itself and no explicit clear is needed
  // between bit samples.
  localparam logic [TW-1:0] SAMPLE_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SAMPLE_BIT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // FSM and frame datapath
  rx_state_t            state_q,     state_d;
  logic [TW-1:0]        tcnt_q,      tcnt_d;
  logic [BW-1:0]        bcnt_q,      bcnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 pen_q,       pen_d;
  logic                 podd_q,      podd_d;
  logic                 perr_pend_q, perr_pend_d;

  // Holding register and registered outputs
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q,  perr_d;
  logic                 ferr_q,  ferr_d;
  logic                 ovr_q,   ovr_d;
  logic                 busy_q,  busy_d;

  logic mid_pt;
  logic bit_pt;
  logic exp_par;
  logic complete;
  logic stop_bad;
  logic load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      pen_q       <= pen_d;
      podd_q      <= podd_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and frame datapath
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    pen_d       = pen_q;
    podd_d      = podd_q;
    perr_pend_d = perr_pend_q;
    complete    = 1'b0;
    stop_bad    = 1'b0;

    mid_pt  = baud_tick && (tcnt_q == SAMPLE_MID);
    bit_pt  = baud_tick && (tcnt_q == SAMPLE_BIT);
    // Value the parity bit must carry for the received data.
    exp_par = podd_q ? ~^shift_q : ^shift_q;

    if (baud_tick) begin
      tcnt_d = tcnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          tcnt_d      = '0;
          bcnt_d      = '0;
          pen_d       = parity_en;
          podd_d      = parity_odd;
          perr_pend_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (mid_pt) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            // Re-zero so the following samples fall at bit centres.
            tcnt_d  = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_pt) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BIT) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_pt) begin
          perr_pend_d = (rx_s != exp_par);
          state_d     = STOP;
        end
      end
      STOP: begin
        if (bit_pt) begin
          complete = 1'b1;
          stop_bad = !rx_s;
          // A low stop bit may be a break. Wait for the line to go high
          // before looking for the next start.
          state_d  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (baud_tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register towards the consumer
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    load = complete && (!valid_q || rx_ready);

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = perr_pend_q;
      ferr_d  = stop_bad;
    end

    ovr_d  = complete && !load;
    busy_d = rx_state_busy(state_d);
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Controls the UART receive path that hangs off the APB peripheral. It oversamples the serial `rx` line at 16x baud, validates the start bit at mid-bit, and shifts in 8 data bits LSB-first. It then checks the optional parity bit and the stop bit, and hands each completed byte to the APB register side through a valid/ready holding register, with parity, framing and overrun status.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit; must be a power of two ≥ 8.
- `DATA_BITS`, 8: data bits per frame.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `baud_tick` in 1: single-cycle enable, `OVERSAMPLE` pulses per bit period.
- `rx` in 1: asynchronous serial line; idles high.
- `parity_en` in 1: parity bit present after the data bits.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even.
- `rx_ready` in 1: the consumer accepts `rx_data` this cycle.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data`, `parity_err` and `frame_err` are valid.
- `parity_err` out 1: the held byte failed its parity check.
- `frame_err` out 1: the held byte's stop bit was sampled low.
- `overrun` out 1: one-cycle pulse; a completed frame was dropped.
- `busy` out 1: a frame is in progress (state is neither IDLE nor WAIT_IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer, preset to 1 on reset, giving `rx_s`. The FSM uses only `rx_s`.
- A 4-bit tick counter `tcnt` advances on `baud_tick`. A sample point is `baud_tick` with `tcnt == OVERSAMPLE/2-1`.
- IDLE: when `rx_s == 0` on a `baud_tick`, clear `tcnt`, latch `parity_en` and `parity_odd`, and go to START. Config changes mid-frame are ignored.
- START: at the sample point, if `rx_s == 1` this is a false start; go to IDLE with no output. Otherwise clear `tcnt` and go to DATA.
- DATA: sample once every `OVERSAMPLE` ticks, at `tcnt == OVERSAMPLE-1` relative to the start mid-point. Shift right with the sample entering bit 7. The bit counter counts 0..7; after bit 7 go to PARITY if parity is latched on, else STOP.
- PARITY: sample the bit. The expected value is `^data` for even parity and `~^data` for odd. On mismatch, set the pending `parity_err`.
- STOP: sample the bit. A sample of 0 sets the pending `frame_err`. Then complete the frame: go to IDLE if the stop bit was 1, else WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s == 1` on a `baud_tick`, then go to IDLE. This prevents a break or low line from retriggering.
- Completion loads `rx_data` and the error flags and sets `rx_valid`, but only if `rx_valid == 0` or `rx_ready == 1` in that cycle.
  - Otherwise the new frame is discarded, `overrun` pulses, and the held byte is unchanged.
- `rx_valid` clears on `rx_valid && rx_ready` unless a completion loads in the same cycle, in which case it stays 1 with the new data.
- Reset mid-frame: all state returns to IDLE immediately and any partial byte is lost.

## Timing
- Every output resets to 0: `rx_data`, `rx_valid`, `parity_err`, `frame_err`, `overrun` and `busy`. Internal state resets to IDLE.
- Synchronizer latency is 2 `clk` cycles.
- Start is detected within 1 tick of `rx_s` falling. The start is confirmed `OVERSAMPLE/2` ticks later.
- `rx_valid` rises in the `clk` cycle after the stop-bit sample tick.
- Frame time from the start edge to `rx_valid` is (1 + 8 + P + 0.5) × `OVERSAMPLE` ticks, where P = 1 with parity and 0 without, plus up to 3 `clk` cycles.
- `rx_ready` is sampled every cycle. Data is held stable while `rx_valid && !rx_ready`.
- `busy` is registered and is high from start detection through the STOP sample.

## Structure
- `uart_pkg`:
  - typedef `rx_state_t` with values {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - constants `UART_OVERSAMPLE=16` and `UART_DATA_BITS=8`, shared with the TX sequencer and the baud generator.
- Sub-module `uart_rx_sync`: a 2-flop synchronizer with reset-to-1. It is reused for GPIO inputs.
- The FSM, counters, shift register and holding register stay in `uart_rx_sequencer`.

## Test plan
- Byte 0xA5, parity on, even, parity bit 0, stop 1 → `rx_data`=0xA5, `rx_valid`=1, `parity_err`=0, `frame_err`=0.
- Byte 0x3C, parity on, odd, parity bit 0 (wrong; odd expects 1) → `rx_data`=0x3C, `parity_err`=1.
- `rx` low for 4 ticks, then high → no `rx_valid`, `busy` drops within 8 ticks, state is IDLE.
- Byte 0x81, parity off, stop bit 0, line held low for 20 ticks → `rx_data`=0x81, `frame_err`=1. No new start until the line has been high, then 0x55 is received correctly.
- Two frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once. With `rx_ready`=1 in the completion cycle of 0x22, `rx_data`=0x22 and there is no `overrun`.
- `rst_n` asserted during DATA bit 4 → all outputs 0 the same cycle. After release, a clean 0xF0 frame is received correctly.
